// File: rtl/phase_seq_ctrl.sv
// Cyclic N-phase sequencer with per-phase dwell and latched requests.
// Define PHASE_SKIP_EN to advance only to phases with a pending request.
module phase_seq_ctrl #(
  parameter  int NUM_PHASES = 4,
  parameter  int DUR_W      = 4,
  localparam int PH_W       = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NUM_PHASES-1:0]       req,
  input  logic [NUM_PHASES*DUR_W-1:0] dur,
  output logic [PH_W-1:0]             phase_idx,
  output logic [NUM_PHASES-1:0]       phase_oh,
  output logic [NUM_PHASES-1:0]       pending,
  output logic                        phase_end,
  output logic                        wrap
);

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DUR_W-1:0]      timer_q, timer_d;
  logic [PH_W-1:0]       idx_q, idx_d;
  logic [NUM_PHASES-1:0] oh_q, oh_d;
  logic [NUM_PHASES-1:0] pend_q, pend_d;
  logic                  end_q, end_d;
  logic                  wrap_q, wrap_d;

  logic [PH_W-1:0]       nxt;
  logic                  adv;
  logic [NUM_PHASES-1:0] entered;
  logic [DUR_W-1:0]      dur_cur;
  logic [DUR_W-1:0]      dur_nxt;

  function automatic logic [PH_W-1:0] mod_add(
    input logic [PH_W-1:0] a,
    input int              k
  );
    int s;
    s = int'(a) + k;
    if (s >= NUM_PHASES) s = s - NUM_PHASES;
    return PH_W'(s);
  endfunction

  function automatic logic [NUM_PHASES-1:0] onehot(
    input logic [PH_W-1:0] i
  );
    logic [NUM_PHASES-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

`ifdef PHASE_SKIP_EN
  // Scan from the far end so the nearest pending offset wins.
  always_comb begin
    logic [PH_W-1:0] cand;
    nxt = idx_q;
    adv = 1'b0;
    for (int k = NUM_PHASES; k >= 1; k--) begin
      cand = mod_add(idx_q, k);
      if (pend_q[cand]) begin
        nxt = cand;
        adv = 1'b1;
      end
    end
  end
`else
  always_comb begin
    nxt = mod_add(idx_q, 1);
    adv = 1'b1;
  end
`endif

  always_comb begin
    dur_cur = dur[int'(idx_q)*DUR_W +: DUR_W];
    dur_nxt = dur[int'(nxt)*DUR_W +: DUR_W];
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    oh_d    = oh_q;
    end_d   = 1'b0;
    wrap_d  = 1'b0;
    entered = '0;
    unique case (state_q)
      LOAD: begin
        timer_d = dur_cur;
        state_d = RUN;
      end
      RUN: begin
        if (en) begin
          if (timer_q != '0) begin
            timer_d = timer_q - DUR_W'(1);
          end else begin
            end_d   = 1'b1;
            timer_d = dur_nxt;
            if (adv) begin
              idx_d   = nxt;
              oh_d    = onehot(nxt);
              wrap_d  = (nxt <= idx_q);
              entered = onehot(nxt);
            end
          end
        end
      end
      default: state_d = LOAD;
    endcase
    pend_d = (pend_q & ~entered) | req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      timer_q <= '0;
      idx_q   <= '0;
      oh_q    <= onehot('0);
      pend_q  <= '0;
      end_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      pend_q  <= pend_d;
      end_q   <= end_d;
      wrap_q  <= wrap_d;
    end
  end

  assign phase_idx = idx_q;
  assign phase_oh  = oh_q;
  assign pending   = pend_q;
  assign phase_end = end_q;
  assign wrap      = wrap_q;

endmodule

// File: doc/phase_seq_ctrl.md
# phase_seq_ctrl

Parametrised cyclic phase sequencer for the small sequential controllers in the benchmark circuit set: an N-phase controller with a per-phase programmable dwell time, latched per-phase requests, and an optional demand-driven phase skip. It replaces fixed 4-state controller logic with a single width- and depth-generic block. It sits between raw request/timing inputs and downstream decode logic, and presents registered phase outputs.

## Interface
- NUM_PHASES, 4, number of phases (2..16; need not be a power of two)
- DUR_W, 4, width of each per-phase dwell field
- PH_W, localparam = max(1, $clog2(NUM_PHASES)), phase index width
- clk  in  1  rising-edge clock, the only clock
- rst  in  1  synchronous, active-high reset
- en  in  1  timer advance enable; 0 freezes timer and phase
- req  in  NUM_PHASES  request pulses; req[i] sets pending[i]
- dur  in  NUM_PHASES*DUR_W  dwell for phase i at dur[i*DUR_W +: DUR_W]; the value is held stable by the source
- phase_idx  out  PH_W  current phase (registered)
- phase_oh  out  NUM_PHASES  one-hot of phase_idx (registered)
- pending  out  NUM_PHASES  latched requests (registered)
- phase_end  out  1  one-cycle pulse on the cycle after a phase expires
- wrap  out  1  one-cycle pulse coincident with phase_end when the index wraps

## Operation
- FSM with 2 states: LOAD, RUN. Reset enters LOAD.
- LOAD lasts 1 cycle. It sets timer <= dur[phase_idx] and moves to RUN. en is ignored in LOAD.
- RUN with en=0: hold everything. pending still updates.
- RUN with en=1 and timer!=0: timer <= timer-1.
- RUN with en=1 and timer==0: this is expiry.
  - Select next; set phase_idx <= next and timer <= dur[next].
  - Assert phase_end. Clear pending[next].
  - wrap = (next <= phase_idx).
- Dwell per phase = dur[i]+1 enabled RUN cycles. dur=0 gives 1 cycle.
- Index arithmetic is modulo NUM_PHASES. No illegal index is ever reached.
- pending[i] next state = (pending[i] & ~entered[i]) | req[i]. If req[i] and entry into phase i occur in the same cycle, set wins.
- phase_oh always equals 1<<phase_idx.

## Timing
- Reset values: phase_idx=0, phase_oh=1, pending=0, phase_end=0, wrap=0, timer=0, state=LOAD.
- All outputs are registered. There is no combinational path from input to output.
- phase_idx, phase_end and wrap change on the same edge, one cycle after the expiry condition is sampled.
- req[i] is visible on pending[i] one cycle after it is sampled.
- rst mid-operation overrides everything on the next edge. In-flight expiry and req in the rst cycle are discarded.
- dur is sampled only in LOAD or at expiry. Changes during a dwell take effect at the next phase entry.

## Configuration
- PHASE_SKIP_EN defined: next = first phase at cyclic offset 1..NUM_PHASES from phase_idx with pending set. Offset NUM_PHASES means the current phase itself, which counts as re-entry, so wrap=1.
- If no phase is pending at expiry: phase_idx is held, timer <= dur[phase_idx], phase_end=1, wrap=0, no pending bit is cleared.
- PHASE_SKIP_EN undefined: next = (phase_idx+1) mod NUM_PHASES unconditionally. pending is latched and cleared identically but does not affect sequencing.

## Test plan
- NUM_PHASES=4, no skip, dur0=1, dur1=2, dur2=0, dur3=3, en=1, rst for 2 cycles.
  - Required: after LOAD, phase 0 held 2 cycles, phase 1 held 3, phase 2 held 1, phase 3 held 4.
  - Steady period is 10 cycles. phase_end is 4 pulses per period; wrap pulses only on the 3->0 transition.
- Same setup, with en low for 5 cycles inside phase 1: phase 1 lasts 8 cycles, the timer value is frozen, and no phase_end occurs while en=0.
- req[2] pulsed while in phase 0: pending=0100 on the next cycle, cleared on the cycle phase_idx becomes 2. Without skip, sequence timing is unchanged.
- PHASE_SKIP_EN, pending=0100, in phase 0 at expiry:
  - phase_idx 0->2, phase_end=1, wrap=0.
  - At the next expiry with pending=0: stays in phase 2, phase_end=1, wrap=0.
- NUM_PHASES=3 without skip (non-power-of-two): the sequence is 0,1,2,0 and phase_idx never equals 3.
- rst asserted in phase 3 with timer=2 and pending=1010:
  - Next cycle: phase_idx=0, phase_oh=0001, pending=0, phase_end=0.
  - LOAD follows, then the normal sequence resumes.
- Same-cycle case: req[1] in the same cycle as entry to phase 1 leaves pending[1]=1.
